reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Out-of-order issue buffer sitting directly downstream of the decoder.
- Accepts decoded ALU-class instructions (issue_rs_ready) and holds them until both source operands are available.
- Snoops the ALU and LSB result broadcasts to wake up waiting operands.
- Dispatches one ready instruction per cycle to the ALU.

Parameters:
- RS_SIZE, 8, number of entries; a power of two, at least 2.
- RS_IDX_W, 3, log2(RS_SIZE).
- ROB_IDX_W, 4, ROB tag width. Tag value 0 means "no dependency / value valid".
- OP_W, 6, width of the OPENUM operation code.
- DATA_W, 32, data and address width.

Ports:
- clk_in, in, 1, clock.
- rst_in, in, 1, asynchronous active-low reset.
- rdy_in, in, 1, global enable; when low, all state holds.
- clr_in, in, 1, mispredict flush (synchronous).
- issue_ready, in, 1, decoder presents an instruction this cycle.
- issue_rs_ready, in, 1, the instruction targets this RS.
- issue_op, in, OP_W, operation code.
- issue_rs1_val, in, DATA_W, operand 1 value.
- issue_rs2_val, in, DATA_W, operand 2 value.
- issue_rs1_depend, in, ROB_IDX_W, operand 1 tag; 0 means the value is valid.
- issue_rs2_depend, in, ROB_IDX_W, operand 2 tag; 0 means the value is valid.
- issue_imm, in, DATA_W, immediate.
- issue_PC, in, DATA_W, instruction PC.
- issue_rob_index, in, ROB_IDX_W, destination ROB tag.
- issue_pred_br, in, 1, predicted-taken flag.
- alu_ready, in, 1, ALU broadcast valid.
- alu_rob_index, in, ROB_IDX_W, ALU broadcast tag.
- alu_result, in, DATA_W, ALU broadcast value.
- lsb_ready, in, 1, LSB broadcast valid.
- lsb_rob_index, in, ROB_IDX_W, LSB broadcast tag.
- lsb_result, in, DATA_W, LSB broadcast value.
- rs_full, out, 1, no free entry; consumed by the decoder stall logic.
- rs_to_alu_valid, out, 1, dispatch valid.
- rs_to_alu_op, out, OP_W, dispatched operation code.
- rs_to_alu_rs1_val, out, DATA_W, dispatched operand 1.
- rs_to_alu_rs2_val, out, DATA_W, dispatched operand 2.
- rs_to_alu_imm, out, DATA_W, dispatched immediate.
- rs_to_alu_PC, out, DATA_W, dispatched PC.
- rs_to_alu_rob_index, out, ROB_IDX_W, dispatched ROB tag.
- rs_to_alu_pred_br, out, 1, dispatched predicted-taken flag.

Behaviour:
- Per-entry state: busy, op, val1, val2, dep1, dep2, imm, PC, rob_index, pred_br.
- Reset (rst_in=0, asynchronous):
  - all busy bits clear;
  - all rs_to_alu_* outputs 0;
  - rs_full=0.
- rdy_in=0: no state change; outputs hold.
- clr_in=1 (rdy_in=1): at the next edge, all busy bits clear and rs_to_alu_valid=0. Any allocate or dispatch in that cycle is discarded.
- Allocate: when issue_ready && issue_rs_ready && !rs_full, write the lowest-index free entry.
  - Forwarding is done by the decoder. However, if a same-cycle alu/lsb broadcast tag matches an incoming nonzero dep, the RS captures that value and writes dep=0.
- Allocate while rs_full: the instruction is ignored. This is a decoder protocol violation; the bench flags it.
- Wakeup: every cycle, for each busy entry and each operand with depN!=0:
  - if alu_ready && alu_rob_index==depN, then valN<=alu_result and depN<=0;
  - otherwise, the same check against the LSB broadcast.
  - If both broadcasts carry the same tag, the ALU wins.
- Ready: an entry is ready when busy && dep1==0 && dep2==0, evaluated on the registered state. A value woken this cycle dispatches at the earliest next cycle.
- Dispatch: select one ready entry (lowest index by default). Its fields are registered onto rs_to_alu_*, rs_to_alu_valid=1 at the next edge, and its busy bit is cleared at that edge.
  - With no ready entry, rs_to_alu_valid<=0 and the other outputs hold.
  - Latency: allocate to dispatch valid is at least 2 cycles.
- Simultaneous allocate and dispatch in one cycle are allowed. The freed slot is not reusable until the next cycle.
- rs_full is combinational: (busy count == RS_SIZE).
- rs_to_alu_valid is a single-cycle pulse per instruction. The ALU has no backpressure.

Optional Feature:
- RS_AGE_PRIORITY_EN.
- When defined: each entry carries an age counter of RS_IDX_W+1 bits.
  - New entry age=0.
  - On each allocate, the ages of existing busy entries increment, saturating.
  - Dispatch selects the ready entry with the largest age; ties go to the lowest index.
- When undefined: lowest-index ready entry wins, and no age storage exists.

Decomposition:
- Shared package holds:
  - OP_W, DATA_W, ROB_IDX_W;
  - the OPENUM_* codes;
  - the NO_DEP=0 constant;
  - the rs_entry struct typedef.
- Sub-module rs_select: takes the ready vector (plus ages under RS_AGE_PRIORITY_EN) and produces grant_valid and grant_idx. The same block is reused for free-slot search.

Test Plan:
1. Reset then allocate ADDI, rs1_val=5, deps 0, imm=3, rob=2: rs_to_alu_valid=1 two cycles later, with rs1_val=5, imm=3, rob_index=2.
2. Allocate ADD with dep1=4. Two cycles later, alu_ready=1, alu_rob_index=4, alu_result=0x10: dispatch one cycle later with rs1_val=0x10.
3. Fill 8 entries, all with dep1=7, so rs_full=1. Issue a ninth: it is ignored. Then broadcast lsb tag 7, value 9: 8 consecutive dispatches, each with rs1_val=9; rs_full drops after the first.
4. ALU and LSB both broadcast tag 3, with values 1 and 2: the waiting entry captures 1.
5. 3 waiting entries, then clr_in for one cycle: no dispatch follows and rs_full=0. A new allocate then dispatches normally.
6. With RS_AGE_PRIORITY_EN: entry 5 allocated before entry 1, both become ready in the same cycle: entry 5 dispatches first. Without the macro, entry 1 dispatches first.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared types and constants for the ALU reservation station.
// Optional build macro: RS_AGE_PRIORITY_EN (oldest-ready-first dispatch).
package reservation_station_pkg;

  localparam int unsigned OP_W      = 6;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ROB_IDX_W = 4;

  localparam logic [ROB_IDX_W-1:0] NO_DEP = '0;

  localparam logic [OP_W-1:0] OPENUM_NOP  = 6'd0;
  localparam logic [OP_W-1:0] OPENUM_ADD  = 6'd1;
  localparam logic [OP_W-1:0] OPENUM_SUB  = 6'd2;
  localparam logic [OP_W-1:0] OPENUM_AND  = 6'd3;
  localparam logic [OP_W-1:0] OPENUM_OR   = 6'd4;
  localparam logic [OP_W-1:0] OPENUM_XOR  = 6'd5;
  localparam logic [OP_W-1:0] OPENUM_ADDI = 6'd6;
  localparam logic [OP_W-1:0] OPENUM_SLTI = 6'd7;
  localparam logic [OP_W-1:0] OPENUM_BEQ  = 6'd8;
  localparam logic [OP_W-1:0] OPENUM_BNE  = 6'd9;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] dep;
    logic [DATA_W-1:0]    val;
  } rs_opnd_t;

  typedef struct packed {
    logic [OP_W-1:0]      op;
    rs_opnd_t             src1;
    rs_opnd_t             src2;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    pc;
    logic [ROB_IDX_W-1:0] rob_index;
    logic                 pred_br;
  } rs_entry_t;

  // ALU broadcast takes precedence when both buses carry the awaited tag.
  function automatic rs_opnd_t wake_opnd(input rs_opnd_t             o,
                                         input logic                 alu_v,
                                         input logic [ROB_IDX_W-1:0] alu_tag,
                                         input logic [DATA_W-1:0]    alu_val,
                                         input logic                 lsb_v,
                                         input logic [ROB_IDX_W-1:0] lsb_tag,
                                         input logic [DATA_W-1:0]    lsb_val);
    rs_opnd_t r;
    r = o;
    if (o.dep != NO_DEP) begin
      if (alu_v && alu_tag == o.dep) begin
        r.val = alu_val;
        r.dep = NO_DEP;
      end else if (lsb_v && lsb_tag == o.dep) begin
        r.val = lsb_val;
        r.dep = NO_DEP;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Picks one requester: lowest index, or largest age (ties to lowest index) when
// RS_AGE_PRIORITY_EN is defined. Used for both dispatch and free-slot search.
module rs_select
  import reservation_station_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]            req_i,
`ifdef RS_AGE_PRIORITY_EN
  input  logic [N-1:0][IDX_W:0]   age_i,
`endif
  output logic                    grant_valid_o,
  output logic [IDX_W-1:0]        grant_idx_o
);

  logic found;
`ifdef RS_AGE_PRIORITY_EN
  logic [IDX_W:0] best;
`endif

  always_comb begin
    found       = 1'b0;
    grant_idx_o = '0;
`ifdef RS_AGE_PRIORITY_EN
    best        = '0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && (!found || age_i[i] > best)) begin
        found       = 1'b1;
        best        = age_i[i];
        grant_idx_o = IDX_W'(i);
      end
    end
`else
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && !found) begin
        found       = 1'b1;
        grant_idx_o = IDX_W'(i);
      end
    end
`endif
    grant_valid_o = found;
  end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: holds decoded ops until operands are ready, wakes on
// ALU/LSB broadcasts, dispatches one per cycle. Macro: RS_AGE_PRIORITY_EN.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned RS_SIZE  = 8,
  parameter int unsigned RS_IDX_W = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clr_in,
  input  logic                 issue_ready,
  input  logic                 issue_rs_ready,
  input  logic [OP_W-1:0]      issue_op,
  input  logic [DATA_W-1:0]    issue_rs1_val,
  input  logic [DATA_W-1:0]    issue_rs2_val,
  input  logic [ROB_IDX_W-1:0] issue_rs1_depend,
  input  logic [ROB_IDX_W-1:0] issue_rs2_depend,
  input  logic [DATA_W-1:0]    issue_imm,
  input  logic [DATA_W-1:0]    issue_PC,
  input  logic [ROB_IDX_W-1:0] issue_rob_index,
  input  logic                 issue_pred_br,
  input  logic                 alu_ready,
  input  logic [ROB_IDX_W-1:0] alu_rob_index,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 lsb_ready,
  input  logic [ROB_IDX_W-1:0] lsb_rob_index,
  input  logic [DATA_W-1:0]    lsb_result,
  output logic                 rs_full,
  output logic                 rs_to_alu_valid,
  output logic [OP_W-1:0]      rs_to_alu_op,
  output logic [DATA_W-1:0]    rs_to_alu_rs1_val,
  output logic [DATA_W-1:0]    rs_to_alu_rs2_val,
  output logic [DATA_W-1:0]    rs_to_alu_imm,
  output logic [DATA_W-1:0]    rs_to_alu_PC,
  output logic [ROB_IDX_W-1:0] rs_to_alu_rob_index,
  output logic                 rs_to_alu_pred_br
);

  logic [RS_SIZE-1:0]  busy_q, busy_d, ready;
  rs_entry_t           entry_q [RS_SIZE];
  rs_entry_t           entry_d [RS_SIZE];
  rs_entry_t           new_entry;
  logic                free_valid, disp_valid, alloc, disp_fire;
  logic [RS_IDX_W-1:0] free_idx, disp_idx;

  logic                 valid_q;
  logic [OP_W-1:0]      op_q;
  logic [DATA_W-1:0]    rs1_q, rs2_q, imm_q, pc_q;
  logic [ROB_IDX_W-1:0] rob_q;
  logic                 pred_br_q;

  assign rs_full   = &busy_q;
  assign alloc     = issue_ready && issue_rs_ready && free_valid;
  assign disp_fire = disp_valid && !clr_in;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = busy_q[i] && entry_q[i].src1.dep == NO_DEP && entry_q[i].src2.dep == NO_DEP;
    end
  end

`ifdef RS_AGE_PRIORITY_EN
  localparam int unsigned AGE_W = RS_IDX_W + 1;
  logic [RS_SIZE-1:0][AGE_W-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (alloc) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && age_q[i] != '1) age_d[i] = age_q[i] + 1'b1;
      end
      age_d[free_idx] = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      age_q <= '0;
    end else if (rdy_in) begin
      age_q <= age_d;
    end
  end
`endif

  rs_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_sel (
    .req_i        (~busy_q),
`ifdef RS_AGE_PRIORITY_EN
    .age_i        ('0),
`endif
    .grant_valid_o(free_valid),
    .grant_idx_o  (free_idx)
  );

  rs_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_disp_sel (
    .req_i        (ready),
`ifdef RS_AGE_PRIORITY_EN
    .age_i        (age_q),
`endif
    .grant_valid_o(disp_valid),
    .grant_idx_o  (disp_idx)
  );

  // Incoming operands may be satisfied by a broadcast in the same cycle.
  always_comb begin
    new_entry.op        = issue_op;
    new_entry.src1      = wake_opnd(rs_opnd_t'{dep: issue_rs1_depend, val: issue_rs1_val},
                                    alu_ready, alu_rob_index, alu_result,
                                    lsb_ready, lsb_rob_index, lsb_result);
    new_entry.src2      = wake_opnd(rs_opnd_t'{dep: issue_rs2_depend, val: issue_rs2_val},
                                    alu_ready, alu_rob_index, alu_result,
                                    lsb_ready, lsb_rob_index, lsb_result);
    new_entry.imm       = issue_imm;
    new_entry.pc        = issue_PC;
    new_entry.rob_index = issue_rob_index;
    new_entry.pred_br   = issue_pred_br;
  end

  always_comb begin
    entry_d = entry_q;
    busy_d  = busy_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i]) begin
        entry_d[i].src1 = wake_opnd(entry_q[i].src1, alu_ready, alu_rob_index, alu_result,
                                    lsb_ready, lsb_rob_index, lsb_result);
        entry_d[i].src2 = wake_opnd(entry_q[i].src2, alu_ready, alu_rob_index, alu_result,
                                    lsb_ready, lsb_rob_index, lsb_result);
      end
    end
    if (disp_valid) busy_d[disp_idx] = 1'b0;
    if (alloc) begin
      busy_d[free_idx]  = 1'b1;
      entry_d[free_idx] = new_entry;
    end
    if (clr_in) busy_d = '0;
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in) entry_q <= entry_d;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q    <= '0;
      valid_q   <= 1'b0;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      rob_q     <= '0;
      pred_br_q <= 1'b0;
    end else if (rdy_in) begin
      busy_q  <= busy_d;
      valid_q <= disp_fire;
      if (disp_fire) begin
        op_q      <= entry_q[disp_idx].op;
        rs1_q     <= entry_q[disp_idx].src1.val;
        rs2_q     <= entry_q[disp_idx].src2.val;
        imm_q     <= entry_q[disp_idx].imm;
        pc_q      <= entry_q[disp_idx].pc;
        rob_q     <= entry_q[disp_idx].rob_index;
        pred_br_q <= entry_q[disp_idx].pred_br;
      end
    end
  end

  assign rs_to_alu_valid     = valid_q;
  assign rs_to_alu_op        = op_q;
  assign rs_to_alu_rs1_val   = rs1_q;
  assign rs_to_alu_rs2_val   = rs2_q;
  assign rs_to_alu_imm       = imm_q;
  assign rs_to_alu_PC        = pc_q;
  assign rs_to_alu_rob_index = rob_q;
  assign rs_to_alu_pred_br   = pred_br_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with an in-bench slot/age model.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int NSLOT   = 8;
  localparam int AGE_MAX = 15;

  logic                 clk_in = 1'b0;
  logic                 rst_in, rdy_in, clr_in;
  logic                 issue_ready, issue_rs_ready, issue_pred_br;
  logic [OP_W-1:0]      issue_op;
  logic [DATA_W-1:0]    issue_rs1_val, issue_rs2_val, issue_imm, issue_PC;
  logic [ROB_IDX_W-1:0] issue_rs1_depend, issue_rs2_depend, issue_rob_index;
  logic                 alu_ready, lsb_ready;
  logic [ROB_IDX_W-1:0] alu_rob_index, lsb_rob_index;
  logic [DATA_W-1:0]    alu_result, lsb_result;
  logic                 rs_full, rs_to_alu_valid, rs_to_alu_pred_br;
  logic [OP_W-1:0]      rs_to_alu_op;
  logic [DATA_W-1:0]    rs_to_alu_rs1_val, rs_to_alu_rs2_val, rs_to_alu_imm, rs_to_alu_PC;
  logic [ROB_IDX_W-1:0] rs_to_alu_rob_index;

  int checks = 0;
  int errors = 0;

  reservation_station dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .rdy_in             (rdy_in),
    .clr_in             (clr_in),
    .issue_ready        (issue_ready),
    .issue_rs_ready     (issue_rs_ready),
    .issue_op           (issue_op),
    .issue_rs1_val      (issue_rs1_val),
    .issue_rs2_val      (issue_rs2_val),
    .issue_rs1_depend   (issue_rs1_depend),
    .issue_rs2_depend   (issue_rs2_depend),
    .issue_imm          (issue_imm),
    .issue_PC           (issue_PC),
    .issue_rob_index    (issue_rob_index),
    .issue_pred_br      (issue_pred_br),
    .alu_ready          (alu_ready),
    .alu_rob_index      (alu_rob_index),
    .alu_result         (alu_result),
    .lsb_ready          (lsb_ready),
    .lsb_rob_index      (lsb_rob_index),
    .lsb_result         (lsb_result),
    .rs_full            (rs_full),
    .rs_to_alu_valid    (rs_to_alu_valid),
    .rs_to_alu_op       (rs_to_alu_op),
    .rs_to_alu_rs1_val  (rs_to_alu_rs1_val),
    .rs_to_alu_rs2_val  (rs_to_alu_rs2_val),
    .rs_to_alu_imm      (rs_to_alu_imm),
    .rs_to_alu_PC       (rs_to_alu_PC),
    .rs_to_alu_rob_index(rs_to_alu_rob_index),
    .rs_to_alu_pred_br  (rs_to_alu_pred_br)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- behavioural model ----------------
  typedef struct {
    bit                   busy;
    logic [OP_W-1:0]      op;
    logic [DATA_W-1:0]    v1, v2, imm, pc;
    logic [ROB_IDX_W-1:0] d1, d2, rob;
    logic                 pb;
    int                   stamp;
  } mslot_t;

  mslot_t               ms [NSLOT];
  int                   n_alloc;
  logic                 m_valid, m_pb;
  logic [OP_W-1:0]      m_op;
  logic [DATA_W-1:0]    m_v1, m_v2, m_imm, m_pc;
  logic [ROB_IDX_W-1:0] m_rob;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NSLOT; i++) if (ms[i].busy) n++;
    return n;
  endfunction

  function automatic bit bcast_hit(input logic [ROB_IDX_W-1:0] tag,
                                   output logic [DATA_W-1:0] val);
    val = '0;
    if (tag == 0) return 1'b0;
    if (alu_ready && alu_rob_index == tag) begin val = alu_result; return 1'b1; end
    if (lsb_ready && lsb_rob_index == tag) begin val = lsb_result; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic model_step();
    int pick, best, slot, a;
    bit full;
    logic [DATA_W-1:0] v;
    pick = -1;
    best = -1;
    for (int i = 0; i < NSLOT; i++) begin
      if (ms[i].busy && ms[i].d1 == 0 && ms[i].d2 == 0) begin
`ifdef RS_AGE_PRIORITY_EN
        a = n_alloc - ms[i].stamp;
        if (a > AGE_MAX) a = AGE_MAX;
        if (a > best) begin best = a; pick = i; end
`else
        if (pick < 0) pick = i;
`endif
      end
    end
    full = (m_count() == NSLOT);
    slot = -1;
    for (int i = 0; i < NSLOT; i++) if (!ms[i].busy && slot < 0) slot = i;
    for (int i = 0; i < NSLOT; i++) begin
      if (ms[i].busy) begin
        if (bcast_hit(ms[i].d1, v)) begin ms[i].v1 = v; ms[i].d1 = 0; end
        if (bcast_hit(ms[i].d2, v)) begin ms[i].v2 = v; ms[i].d2 = 0; end
      end
    end
    m_valid = (pick >= 0);
    if (pick >= 0) begin
      m_op = ms[pick].op;   m_v1 = ms[pick].v1;   m_v2 = ms[pick].v2;
      m_imm = ms[pick].imm; m_pc = ms[pick].pc;   m_rob = ms[pick].rob;
      m_pb = ms[pick].pb;   ms[pick].busy = 0;
    end
    if (issue_ready && issue_rs_ready) begin
      if (full) begin
        $display("note: decoder protocol violation, issue rob %0d while full ignored",
                 issue_rob_index);
      end else begin
        n_alloc++;
        ms[slot].busy = 1; ms[slot].op = issue_op; ms[slot].imm = issue_imm;
        ms[slot].pc = issue_PC; ms[slot].rob = issue_rob_index; ms[slot].pb = issue_pred_br;
        ms[slot].v1 = issue_rs1_val; ms[slot].d1 = issue_rs1_depend;
        ms[slot].v2 = issue_rs2_val; ms[slot].d2 = issue_rs2_depend;
        if (bcast_hit(ms[slot].d1, v)) begin ms[slot].v1 = v; ms[slot].d1 = 0; end
        if (bcast_hit(ms[slot].d2, v)) begin ms[slot].v2 = v; ms[slot].d2 = 0; end
        ms[slot].stamp = n_alloc;
      end
    end
  endtask

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NSLOT; i++) ms[i].busy = 0;
      n_alloc = 0;
      m_valid = 0; m_op = '0; m_v1 = '0; m_v2 = '0; m_imm = '0; m_pc = '0;
      m_rob = '0; m_pb = 0;
    end else if (rdy_in) begin
      if (clr_in) begin
        for (int i = 0; i < NSLOT; i++) ms[i].busy = 0;
        m_valid = 0;
      end else begin
        model_step();
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_in) begin
    if (rst_in) begin
      checks++;
      if ({rs_to_alu_valid, rs_to_alu_op, rs_to_alu_rs1_val, rs_to_alu_rs2_val, rs_to_alu_imm,
           rs_to_alu_PC, rs_to_alu_rob_index, rs_to_alu_pred_br, rs_full} !==
          {m_valid, m_op, m_v1, m_v2, m_imm, m_pc, m_rob, m_pb, 1'(m_count() == NSLOT)}) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got v=%0b op=%0h rs1=%0h rs2=%0h imm=%0h pc=%0h rob=%0h pb=%0b full=%0b; expected v=%0b op=%0h rs1=%0h rs2=%0h imm=%0h pc=%0h rob=%0h pb=%0b full=%0b",
                 $time, rs_to_alu_valid, rs_to_alu_op, rs_to_alu_rs1_val, rs_to_alu_rs2_val,
                 rs_to_alu_imm, rs_to_alu_PC, rs_to_alu_rob_index, rs_to_alu_pred_br, rs_full,
                 m_valid, m_op, m_v1, m_v2, m_imm, m_pc, m_rob, m_pb, m_count() == NSLOT);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    issue_ready = 0; issue_rs_ready = 0; alu_ready = 0; lsb_ready = 0; clr_in = 0;
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
    idle();
  endtask

  task automatic issue(input logic [OP_W-1:0] op, input logic [31:0] v1,
                       input logic [3:0] d1, input logic [31:0] v2, input logic [3:0] d2,
                       input logic [31:0] imm, input logic [3:0] rob);
    issue_ready = 1; issue_rs_ready = 1; issue_op = op;
    issue_rs1_val = v1; issue_rs1_depend = d1; issue_rs2_val = v2; issue_rs2_depend = d2;
    issue_imm = imm; issue_PC = 32'h1000 + 32'(rob) * 4; issue_rob_index = rob;
    issue_pred_br = rob[0];
  endtask

  task automatic alu_bc(input logic [3:0] tag, input logic [31:0] val);
    alu_ready = 1; alu_rob_index = tag; alu_result = val;
  endtask

  task automatic lsb_bc(input logic [3:0] tag, input logic [31:0] val);
    lsb_ready = 1; lsb_rob_index = tag; lsb_result = val;
  endtask

  initial begin
    rst_in = 0; rdy_in = 1;
    issue_op = '0; issue_rs1_val = '0; issue_rs2_val = '0; issue_imm = '0; issue_PC = '0;
    issue_rs1_depend = '0; issue_rs2_depend = '0; issue_rob_index = '0; issue_pred_br = 0;
    alu_rob_index = '0; alu_result = '0; lsb_rob_index = '0; lsb_result = '0;
    idle();
    repeat (2) @(posedge clk_in);
    #1;
    lit("rst_valid", 32'(rs_to_alu_valid), 0);
    lit("rst_full", 32'(rs_full), 0);
    lit("rst_op", 32'(rs_to_alu_op), 0);
    lit("rst_rob", 32'(rs_to_alu_rob_index), 0);
    lit("rst_rs1", rs_to_alu_rs1_val, 0);
    rst_in = 1;
    cyc();

    // 1: ready-at-issue ADDI, two-edge latency
    issue(OPENUM_ADDI, 5, 0, 0, 0, 3, 2);
    cyc();
    lit("t1_not_yet", 32'(rs_to_alu_valid), 0);
    cyc();
    lit("t1_valid", 32'(rs_to_alu_valid), 1);
    lit("t1_rs1", rs_to_alu_rs1_val, 5);
    lit("t1_imm", rs_to_alu_imm, 3);
    lit("t1_rob", 32'(rs_to_alu_rob_index), 2);
    lit("t1_pc", rs_to_alu_PC, 32'h1008);
    cyc();
    lit("t1_pulse", 32'(rs_to_alu_valid), 0);

    // 2: ALU wakeup
    issue(OPENUM_ADD, 0, 4, 32'h22, 0, 0, 5);
    cyc();
    cyc();
    alu_bc(4, 32'h10);
    cyc();
    lit("t2_wait", 32'(rs_to_alu_valid), 0);
    cyc();
    lit("t2_valid", 32'(rs_to_alu_valid), 1);
    lit("t2_rs1", rs_to_alu_rs1_val, 32'h10);
    lit("t2_rs2", rs_to_alu_rs2_val, 32'h22);
    cyc();

    // 3: fill, overflow issue, LSB wakeup of all
    for (int i = 0; i < 8; i++) begin
      issue(OPENUM_SUB, 0, 7, 32'(i), 0, 0, 4'(8 + i));
      cyc();
    end
    lit("t3_full", 32'(rs_full), 1);
    issue(OPENUM_XOR, 32'hDEAD, 0, 0, 0, 0, 3);
    cyc();
    lit("t3_still_full", 32'(rs_full), 1);
    lit("t3_no_disp", 32'(rs_to_alu_valid), 0);
    lsb_bc(7, 9);
    cyc();
    lit("t3_wake_full", 32'(rs_full), 1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      lit("t3_valid", 32'(rs_to_alu_valid), 1);
      lit("t3_rs1", rs_to_alu_rs1_val, 9);
      lit("t3_rob", 32'(rs_to_alu_rob_index), 32'(8 + i));
      if (i == 0) lit("t3_full_drop", 32'(rs_full), 0);
    end
    cyc();
    lit("t3_drained", 32'(rs_to_alu_valid), 0);

    // 4: same tag on both buses, ALU wins
    issue(OPENUM_OR, 32'h20, 0, 0, 3, 0, 1);
    cyc();
    alu_bc(3, 1);
    lsb_bc(3, 2);
    cyc();
    cyc();
    lit("t4_valid", 32'(rs_to_alu_valid), 1);
    lit("t4_rs2", rs_to_alu_rs2_val, 1);
    cyc();

    // capture of a broadcast at allocation time
    issue(OPENUM_AND, 0, 6, 0, 0, 0, 9);
    alu_bc(6, 32'hAB);
    cyc();
    cyc();
    lit("cap_valid", 32'(rs_to_alu_valid), 1);
    lit("cap_rs1", rs_to_alu_rs1_val, 32'hAB);
    cyc();

    // 5: flush
    for (int i = 0; i < 3; i++) begin
      issue(OPENUM_ADD, 0, 9, 0, 0, 0, 4'(1 + i));
      cyc();
    end
    clr_in = 1;
    cyc();
    lit("t5_valid", 32'(rs_to_alu_valid), 0);
    lit("t5_full", 32'(rs_full), 0);
    alu_bc(9, 32'h99);
    cyc();
    cyc();
    lit("t5_no_disp", 32'(rs_to_alu_valid), 0);
    issue(OPENUM_ADDI, 32'h77, 0, 0, 0, 1, 4);
    cyc();
    cyc();
    lit("t5_new_valid", 32'(rs_to_alu_valid), 1);
    lit("t5_new_rob", 32'(rs_to_alu_rob_index), 4);
    cyc();

    // rdy_in low holds all state and outputs
    issue(OPENUM_SLTI, 32'h55, 0, 0, 0, 0, 5);
    cyc();
    rdy_in = 0;
    cyc();
    cyc();
    lit("rdy_hold_idle", 32'(rs_to_alu_valid), 0);
    rdy_in = 1;
    cyc();
    lit("rdy_disp", 32'(rs_to_alu_valid), 1);
    lit("rdy_rob", 32'(rs_to_alu_rob_index), 5);
    rdy_in = 0;
    cyc();
    lit("rdy_hold_valid", 32'(rs_to_alu_valid), 1);
    rdy_in = 1;
    cyc();
    lit("rdy_resume", 32'(rs_to_alu_valid), 0);

    // 6: entry 5 older than entry 1, both wake together
    issue(OPENUM_ADD, 0, 2, 0, 0, 0, 1);
    cyc();
    issue(OPENUM_ADD, 0, 3, 0, 0, 0, 2);
    cyc();
    for (int i = 0; i < 3; i++) begin
      issue(OPENUM_ADD, 0, 2, 0, 0, 0, 4'(3 + i));
      cyc();
    end
    issue(OPENUM_BEQ, 0, 5, 0, 0, 0, 6);
    cyc();
    alu_bc(3, 0);
    cyc();
    cyc();
    lit("t6_free_e1", 32'(rs_to_alu_rob_index), 2);
    issue(OPENUM_BNE, 0, 5, 0, 0, 0, 7);
    cyc();
    alu_bc(5, 32'h5);
    cyc();
    cyc();
`ifdef RS_AGE_PRIORITY_EN
    lit("t6_first", 32'(rs_to_alu_rob_index), 6);
    cyc();
    lit("t6_second", 32'(rs_to_alu_rob_index), 7);
`else
    lit("t6_first", 32'(rs_to_alu_rob_index), 7);
    cyc();
    lit("t6_second", 32'(rs_to_alu_rob_index), 6);
`endif
    lsb_bc(2, 32'h44);
    cyc();
    repeat (6) cyc();
    lit("t6_empty", 32'(rs_full), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
